ad_ip_jesd204_tpl_adc_pn_sweep: RTL and testbench
=================================================

Name: ad_ip_jesd204_tpl_adc_pn_sweep

Overview:
Sequencer that runs a PN-pattern self-test across every channel of the JESD204 TPL ADC datapath, one channel at a time. For each channel it drives that channel's pn_seq_sel, waits for the checker to lock, then monitors pn_err for a programmable dwell. It records per-channel pass/timeout results and restores normal-data selection when finished. It sits between the register map (start/abort/config) and the per-channel PN monitors of the TPL ADC core.

Parameters:
NUM_CHANNELS, 1, number of converter channels swept (index 0 upward).
SETTLE_CYCLES, 16, cycles waited after changing pn_seq_sel before lock monitoring starts (>=1).
LOCK_TIMEOUT, 1024, maximum cycles allowed for pn_oos to deassert once settled (>=1).
DWELL_WIDTH, 16, width of the dwell_cycles input.

Ports:
clk  in  1  core/link clock; all logic on rising edge.
resetn  in  1  asynchronous active-low reset.
start  in  1  single-cycle request; accepted only in IDLE.
abort  in  1  level; forces return to IDLE from any state.
pattern  in  4  pn_seq_sel code applied to the channel under test; sampled at start.
dwell_cycles  in  DWELL_WIDTH  error-free cycles required after lock; sampled at start; 0 treated as 1.
pn_seq_sel  out  NUM_CHANNELS*4  per-channel sequence select to the TPL core; 4'h0 = normal data.
pn_err  in  NUM_CHANNELS  per-channel PN error from the core.
pn_oos  in  NUM_CHANNELS  per-channel PN out-of-sync from the core.
busy  out  1  high from the cycle after start is accepted until DONE is exited.
done  out  1  one-cycle pulse when the sweep completes without abort.
active_channel  out  max(1,clog2(NUM_CHANNELS))  index of the channel under test; 0 when idle.
result_pass  out  NUM_CHANNELS  bit i = channel i locked and dwelled with no error.
result_timeout  out  NUM_CHANNELS  bit i = channel i never locked within LOCK_TIMEOUT.

Behaviour:
- Reset (async assert, sync release): state IDLE; pn_seq_sel=0; busy=0; done=0; active_channel=0; results=0; all counters=0.
- pn_err/pn_oos are registered once on entry. All decisions use the registered values, which lag the inputs by 1 cycle.
- States:
  - IDLE: start=1 and abort=0 -> clear result_pass/result_timeout; latch pattern and dwell; channel=0; go to SETUP.
  - SETUP (1 cycle): pn_seq_sel[ch*4+:4]=pattern with all other nibbles 0; load settle counter with SETTLE_CYCLES-1 -> SETTLE.
  - SETTLE: decrement the counter; at 0 load the timeout counter with LOCK_TIMEOUT-1 -> LOCK.
  - LOCK: when registered pn_oos[ch]=0, load the dwell counter with max(dwell,1)-1 -> DWELL. Otherwise decrement. If the counter is 0 and oos is still 1 -> set result_timeout[ch], go to NEXT.
  - DWELL: registered pn_err[ch]=1 or pn_oos[ch]=1 -> go to NEXT with pass bit left 0. When the counter reaches 0 with no error that cycle -> set result_pass[ch], go to NEXT.
  - NEXT (1 cycle): clear nibble ch to 0. If ch==NUM_CHANNELS-1 -> DONE; else ch+1 -> SETUP.
  - DONE (1 cycle): done=1 -> IDLE.
- busy = (state != IDLE).
- active_channel tracks ch while busy and returns to 0 in IDLE.
- At most one pn_seq_sel nibble is non-zero at any time.
- abort (any non-IDLE state): next cycle pn_seq_sel=0, state IDLE, no done pulse. Results already set are kept; the bit for the current channel stays 0.
- start while busy is ignored. start and abort together in IDLE: abort wins, no sweep.
- pass and timeout are mutually exclusive per channel. Both 0 means the channel locked and then erred.
- Result bits update on the cycle the state leaves LOCK/DWELL and are stable after done.
- Minimum per-channel time: 1 (SETUP) + SETTLE_CYCLES + 1 (lock-detect) + max(dwell,1) + 1 (NEXT) cycles.

Test Plan:
- NUM_CHANNELS=4, pattern=4'h5, dwell=100, pn_oos drops 3 cycles after settle, pn_err=0 -> pn_seq_sel walks 0x0005, 0x0050, 0x0500, 0x5000, then 0; done pulses once; result_pass=4'hF, result_timeout=0.
- Channel 2 pn_oos held high -> exactly LOCK_TIMEOUT cycles spent in LOCK; result_timeout=4'b0100, result_pass=4'b1011; sweep continues to channel 3.
- Channel 1 pn_err pulses at dwell cycle 50 -> result_pass=4'b1101, result_timeout=0; channel 1 leaves DWELL early.
- abort asserted while channel 2 is in DWELL -> next cycle pn_seq_sel=0 and busy=0, no done; result_pass=4'b0011 retained.
- start re-pulsed while busy, then start+abort together in IDLE -> no restart and no state change; results unchanged.
- resetn asserted mid-SETTLE -> outputs zero asynchronously; after release, a fresh start runs a full sweep.

Source files
------------

// File: rtl/ad_ip_jesd204_tpl_adc_pn_sweep.sv
// ad_ip_jesd204_tpl_adc_pn_sweep -- sequential per-channel PN self-test of the TPL ADC datapath.
// rev 1.0
`default_nettype none

module ad_ip_jesd204_tpl_adc_pn_sweep #(
    parameter int NUM_CHANNELS  = 1,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int DWELL_WIDTH   = 16,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic                      abort,
    input  logic [3:0]                pattern,
    input  logic [DWELL_WIDTH-1:0]    dwell_cycles,
    output logic [NUM_CHANNELS*4-1:0] pn_seq_sel,
    input  logic [NUM_CHANNELS-1:0]   pn_err,
    input  logic [NUM_CHANNELS-1:0]   pn_oos,
    output logic                      busy,
    output logic                      done,
    output logic [CH_W-1:0]           active_channel,
    output logic [NUM_CHANNELS-1:0]   result_pass,
    output logic [NUM_CHANNELS-1:0]   result_timeout
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int LT_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int CNT_W = (DWELL_WIDTH > SET_W) ? ((DWELL_WIDTH > LT_W) ? DWELL_WIDTH : LT_W)
                                                 : ((SET_W > LT_W) ? SET_W : LT_W);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CHANNELS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_LOCK   = 3'd3;
    localparam logic [2:0] S_DWELL  = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]                state_q,   state_d;
    logic [CH_W-1:0]           ch_q,      ch_d;
    logic [CNT_W-1:0]          cnt_q,     cnt_d;
    logic [3:0]                pattern_q, pattern_d;
    logic [DWELL_WIDTH-1:0]    dwell_q,   dwell_d;
    logic [NUM_CHANNELS*4-1:0] sel_q,     sel_d;
    logic [NUM_CHANNELS-1:0]   pass_q,    pass_d;
    logic [NUM_CHANNELS-1:0]   tmo_q,     tmo_d;
    logic [NUM_CHANNELS-1:0]   err_q;
    logic [NUM_CHANNELS-1:0]   oos_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            pattern_q <= '0;
            dwell_q   <= '0;
            sel_q     <= '0;
            pass_q    <= '0;
            tmo_q     <= '0;
            err_q     <= '0;
            oos_q     <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            dwell_q   <= dwell_d;
            sel_q     <= sel_d;
            pass_q    <= pass_d;
            tmo_q     <= tmo_d;
            err_q     <= pn_err;
            oos_q     <= pn_oos;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        dwell_d   = dwell_q;
        sel_d     = sel_q;
        pass_d    = pass_q;
        tmo_d     = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    pass_d    = '0;
                    tmo_d     = '0;
                    pattern_d = pattern;
                    dwell_d   = (dwell_cycles == '0) ? DWELL_WIDTH'(1) : dwell_cycles;
                    ch_d      = '0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                sel_d               = '0;
                sel_d[ch_q*4 +: 4]  = pattern_q;
                cnt_d               = SETTLE_LOAD;
                state_d             = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    cnt_d   = LOCK_LOAD;
                    state_d = S_LOCK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LOCK: begin
                if (!oos_q[ch_q]) begin
                    cnt_d   = CNT_W'(dwell_q - DWELL_WIDTH'(1));
                    state_d = S_DWELL;
                end else if (cnt_q == '0) begin
                    tmo_d[ch_q] = 1'b1;
                    state_d     = S_NEXT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DWELL: begin
                // Any error or loss of sync ends the dwell with the pass bit left clear.
                if (err_q[ch_q] || oos_q[ch_q]) begin
                    state_d = S_NEXT;
                end else if (cnt_q == '0) begin
                    pass_d[ch_q] = 1'b1;
                    state_d      = S_NEXT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_NEXT: begin
                sel_d = '0;
                if (ch_q == LAST_CH) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_SETUP;
                end
            end
            S_DONE: begin
                ch_d    = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort discards any result decided this cycle; earlier channels keep theirs.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            sel_d   = '0;
            ch_d    = '0;
            cnt_d   = '0;
            pass_d  = pass_q;
            tmo_d   = tmo_q;
        end
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        active_channel = (state_q != S_IDLE) ? ch_q : '0;
        pn_seq_sel     = sel_q;
        result_pass    = pass_q;
        result_timeout = tmo_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_sweep.sv
// tb_ad_ip_jesd204_tpl_adc_pn_sweep -- vector table plus scoreboard for the PN sweep sequencer.
// rev 1.0
`default_nettype none

module tb_ad_ip_jesd204_tpl_adc_pn_sweep;

    localparam int NCH = 4;
    localparam int S   = 16;
    localparam int LT  = 64;
    localparam int DW  = 16;

    logic            clk          = 1'b0;
    logic            resetn       = 1'b0;
    logic            start        = 1'b0;
    logic            abort_model  = 1'b0;
    logic            abort_manual = 1'b0;
    logic            abort;
    logic [3:0]      pattern      = 4'h0;
    logic [DW-1:0]   dwell_cycles = '0;
    logic [NCH*4-1:0] pn_seq_sel;
    logic [NCH-1:0]  pn_err       = '0;
    logic [NCH-1:0]  pn_oos       = '1;
    logic            busy;
    logic            done;
    logic [1:0]      active_channel;
    logic [NCH-1:0]  result_pass;
    logic [NCH-1:0]  result_timeout;

    assign abort = abort_model | abort_manual;

    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_adc_pn_sweep #(
        .NUM_CHANNELS (NCH),
        .SETTLE_CYCLES(S),
        .LOCK_TIMEOUT (LT),
        .DWELL_WIDTH  (DW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .abort         (abort),
        .pattern       (pattern),
        .dwell_cycles  (dwell_cycles),
        .pn_seq_sel    (pn_seq_sel),
        .pn_err        (pn_err),
        .pn_oos        (pn_oos),
        .busy          (busy),
        .done          (done),
        .active_channel(active_channel),
        .result_pass   (result_pass),
        .result_timeout(result_timeout)
    );

    typedef struct {
        logic [3:0] pat;
        int         dwell;
        logic [3:0] hold;
        int         err_ch;
        int         abort_ch;
        bit         restart;
        logic [3:0] exp_pass;
        logic [3:0] exp_to;
        bit         exp_done;
    } vec_t;

    typedef struct packed {
        logic [3:0]            pass;
        logic [3:0]            to;
        logic [7:0]            done_n;
        logic [NCH-1:0][15:0]  dur;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    int errors = 0;
    int checks = 0;

    // Stimulus context shared with the PN-core model (written only by the main process).
    logic [3:0] cur_pat      = 4'h0;
    logic [3:0] cur_hold     = 4'h0;
    int         cur_err_ch   = -1;
    int         cur_abort_ch = -1;

    // PN-core model and observation records (written only by the monitor).
    int         age   [NCH];
    int         dur_m [NCH];
    int         done_m       = 0;
    bit         inv_bad      = 1'b0;
    logic       busy_prev    = 1'b0;
    bit         abort_pend   = 1'b0;
    bit         post_valid   = 1'b0;
    logic [15:0] post_sel    = '0;
    logic       post_busy    = 1'b0;

    initial begin
        for (int i = 0; i < NCH; i++) begin
            age[i]   = 0;
            dur_m[i] = 0;
        end
    end

    always @(negedge clk) begin
        int nz;
        logic [3:0] nib;
        if (busy && !busy_prev) begin
            for (int i = 0; i < NCH; i++) dur_m[i] = 0;
            done_m     = 0;
            inv_bad    = 1'b0;
            post_valid = 1'b0;
        end
        busy_prev = busy;
        if (abort_pend) begin
            post_sel   = pn_seq_sel;
            post_busy  = busy;
            post_valid = 1'b1;
            abort_pend = 1'b0;
        end
        abort_model = 1'b0;
        nz = 0;
        for (int i = 0; i < NCH; i++) begin
            nib = pn_seq_sel[i*4 +: 4];
            if (nib != 4'h0) begin
                age[i]   = age[i] + 1;
                dur_m[i] = dur_m[i] + 1;
                nz       = nz + 1;
                if (nib != cur_pat || int'(active_channel) != i) inv_bad = 1'b1;
            end else begin
                age[i] = 0;
            end
            pn_oos[i] = (cur_hold[i] || age[i] < S + 3);
            pn_err[i] = (cur_err_ch == i) && (age[i] == S + 4 + 50);
            if (cur_abort_ch == i && age[i] == 40) begin
                abort_model = 1'b1;
                abort_pend  = 1'b1;
            end
        end
        if (nz > 1) inv_bad = 1'b1;
        if (done) done_m = done_m + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t expect_of(input vec_t v);
        exp_t e;
        int d;
        d = (v.dwell == 0) ? 1 : v.dwell;
        e.pass   = v.exp_pass;
        e.to     = v.exp_to;
        e.done_n = v.exp_done ? 8'd1 : 8'd0;
        for (int i = 0; i < NCH; i++) begin
            if (v.abort_ch >= 0 && i > v.abort_ch)  e.dur[i] = 16'd0;
            else if (i == v.abort_ch)               e.dur[i] = 16'd40;
            else if (v.hold[i])                     e.dur[i] = 16'(S + LT + 1);
            else if (i == v.err_ch)                 e.dur[i] = 16'(S + 4 + 50 + 2);
            else                                    e.dur[i] = 16'(S + 5 + d);
        end
        return e;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   n;
        bit   idle;
        sb_q.push_back(expect_of(v));
        cur_pat      = v.pat;
        cur_hold     = v.hold;
        cur_err_ch   = v.err_ch;
        cur_abort_ch = v.abort_ch;
        pattern      = v.pat;
        dwell_cycles = DW'(v.dwell);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        pattern      = 4'hF;
        dwell_cycles = DW'(3);
        #1;
        check($sformatf("v%0d busy_after_start", idx), busy, 1);
        n    = 0;
        idle = 1'b0;
        while (n < 3000 && !idle) begin
            @(negedge clk);
            #1;
            n++;
            start = (v.restart && n == 50);
            if (!busy) idle = 1'b1;
        end
        start = 1'b0;
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL v%0d sweep_end: busy still high after %0d cycles", idx, n);
        end
        e = sb_q.pop_front();
        check($sformatf("v%0d result_pass", idx), result_pass, e.pass);
        check($sformatf("v%0d result_timeout", idx), result_timeout, e.to);
        check($sformatf("v%0d done_pulses", idx), done_m, e.done_n);
        for (int i = 0; i < NCH; i++)
            check($sformatf("v%0d ch%0d sel_cycles", idx, i), dur_m[i], e.dur[i]);
        check($sformatf("v%0d sel_nibble_invariant", idx), inv_bad, 0);
        if (v.abort_ch >= 0) begin
            check($sformatf("v%0d abort_observed", idx), post_valid, 1);
            check($sformatf("v%0d abort_sel_zero", idx), post_sel, 0);
            check($sformatf("v%0d abort_busy_low", idx), post_busy, 0);
        end
    endtask

    initial begin
        vecs[0] = '{4'h5, 100, 4'b0000, -1, -1, 1'b0, 4'hF,    4'h0,    1'b1};
        vecs[1] = '{4'h5, 100, 4'b0100, -1, -1, 1'b1, 4'b1011, 4'b0100, 1'b1};
        vecs[2] = '{4'h5, 100, 4'b0000,  1, -1, 1'b0, 4'b1101, 4'h0,    1'b1};
        vecs[3] = '{4'h5, 100, 4'b0000, -1,  2, 1'b0, 4'b0011, 4'h0,    1'b0};
        vecs[4] = '{4'hA,   0, 4'b0000, -1, -1, 1'b0, 4'hF,    4'h0,    1'b1};
        vecs[5] = '{4'h3,   1, 4'b1001, -1, -1, 1'b0, 4'b0110, 4'b1001, 1'b1};

        repeat (2) @(negedge clk);
        #1;
        check("reset pn_seq_sel", pn_seq_sel, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset active_channel", active_channel, 0);
        check("reset result_pass", result_pass, 0);
        check("reset result_timeout", result_timeout, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], k);
            if (k == 2) begin
                // start and abort together in IDLE: no sweep, results untouched
                @(negedge clk);
                start        = 1'b1;
                abort_manual = 1'b1;
                @(negedge clk);
                start        = 1'b0;
                abort_manual = 1'b0;
                #1;
                check("idle start+abort busy", busy, 0);
                check("idle start+abort sel", pn_seq_sel, 0);
                check("idle start+abort pass", result_pass, 4'b1101);
                check("idle start+abort timeout", result_timeout, 4'b0000);
                repeat (3) @(negedge clk);
                #1;
                check("idle start+abort busy_later", busy, 0);
            end
        end

        // async reset in the middle of channel 0 settle
        cur_pat      = 4'h5;
        cur_hold     = 4'h0;
        cur_err_ch   = -1;
        cur_abort_ch = -1;
        pattern      = 4'h5;
        dwell_cycles = DW'(100);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("mid-settle sel", pn_seq_sel, 16'h0005);
        resetn = 1'b0;
        #1;
        check("async reset sel", pn_seq_sel, 0);
        check("async reset busy", busy, 0);
        check("async reset active_channel", active_channel, 0);
        check("async reset pass", result_pass, 0);
        check("async reset timeout", result_timeout, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(vecs[0], 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
